ir_decode_seq: RTL

- Instruction decoder and microsequencer for the Hmmm core.
- Consumes the 16-bit instruction word held by the instruction register.
- Drives that register's load/drive strobes (ir_in, ir_out) and every other shared-data-bus enable: PC, MAR, memory, register file and ALU.
- Sequences fetch, decode and execute as a Moore FSM.
- Owns the single-bus-driver discipline of the core.

---
 rtl/hmmm_pkg.sv | 81 ++++++++
 rtl/hmmm_cond_eval.sv | 23 ++
 rtl/ir_decode_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hmmm_pkg.sv
// Shared definitions for the Hmmm core control path: opcodes, ALU op codes,
// sequencer states and the instruction-class decoder.
package hmmm_pkg;

  localparam logic [3:0] OP_SYS    = 4'h0;
  localparam logic [3:0] OP_SETN   = 4'h1;
  localparam logic [3:0] OP_LOADN  = 4'h2;
  localparam logic [3:0] OP_STOREN = 4'h3;
  localparam logic [3:0] OP_ADDN   = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_DIV    = 4'h9;
  localparam logic [3:0] OP_MOD    = 4'hA;
  localparam logic [3:0] OP_JUMPN  = 4'hB;
  localparam logic [3:0] OP_JEQZN  = 4'hC;
  localparam logic [3:0] OP_JNEZN  = 4'hD;
  localparam logic [3:0] OP_JGTZN  = 4'hE;
  localparam logic [3:0] OP_JLTZN  = 4'hF;

  localparam logic [15:0] INSTR_HALT = 16'h0000;
  localparam logic [15:0] INSTR_NOP  = 16'h6000;
  localparam logic [7:0]  FUNC_JUMPR = 8'h03;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_DIV  = 3'd3;
  localparam logic [2:0] ALU_MOD  = 3'd4;
  localparam logic [2:0] ALU_ADDI = 3'd5;
  localparam logic [2:0] ALU_SEXT = 3'd6;

  typedef enum logic [2:0] {
    StIdle, StF0, StF1, StD, StE0, StE1, StE2, StHlt
  } state_e;

  typedef enum logic [3:0] {
    ClsHalt, ClsJumpr, ClsSetn, ClsLoadn, ClsStoren, ClsAddn, ClsNop,
    ClsCopy, ClsAlu, ClsJumpn, ClsCalln, ClsBranch, ClsIllegal
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(input logic [15:0] ir);
    instr_cls_e cls;
    cls = ClsIllegal;
    case (ir[15:12])
      OP_SYS: begin
        if (ir == INSTR_HALT)            cls = ClsHalt;
        else if (ir[7:0] == FUNC_JUMPR)  cls = ClsJumpr;
        else                             cls = ClsIllegal;
      end
      OP_SETN:   cls = ClsSetn;
      OP_LOADN:  cls = ClsLoadn;
      OP_STOREN: cls = ClsStoren;
      OP_ADDN:   cls = ClsAddn;
      OP_ADD: begin
        // 0x6000 would otherwise decode as "copy r0, r0"
        if (ir == INSTR_NOP)         cls = ClsNop;
        else if (ir[3:0] == 4'h0)    cls = ClsCopy;
        else                         cls = ClsAlu;
      end
      OP_SUB, OP_MUL, OP_DIV, OP_MOD: cls = ClsAlu;
      OP_JUMPN:  cls = (ir[11:8] == 4'h0) ? ClsJumpn : ClsCalln;
      OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: cls = ClsBranch;
      default:   cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] res;
    case (op)
      OP_SUB:  res = ALU_SUB;
      OP_MUL:  res = ALU_MUL;
      OP_DIV:  res = ALU_DIV;
      OP_MOD:  res = ALU_MOD;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hmmm_cond_eval.sv
// Conditional-jump evaluator: decides branch-taken from the jump opcode and
// the zero/negative flags of the register value currently on the bus.
module hmmm_cond_eval
  import hmmm_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_rf_zero,
  input  logic       i_rf_neg,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      OP_JEQZN: o_taken = i_rf_zero;
      OP_JNEZN: o_taken = ~i_rf_zero;
      OP_JGTZN: o_taken = ~i_rf_zero & ~i_rf_neg;
      OP_JLTZN: o_taken = i_rf_neg;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ir_decode_seq.sv
// Hmmm instruction decoder and Moore microsequencer (fetch, decode, execute).
// Build option HMMM_ILLEGAL_TRAP_EN: illegal opcodes halt the core instead of acting as NOP.
module ir_decode_seq
  import hmmm_pkg::*;
#(
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [15:0]         i_ir_data,
  input  logic                i_mem_ready,
  input  logic                i_rf_zero,
  input  logic                i_rf_neg,
  output logic                o_ir_in,
  output logic                o_ir_out,
  output logic                o_pc_out,
  output logic                o_pc_in,
  output logic                o_pc_inc,
  output logic                o_mar_in,
  output logic                o_mem_out,
  output logic                o_mem_wr,
  output logic                o_rf_out,
  output logic                o_rf_in,
  output logic [SEL_W-1:0]    o_rf_rsel,
  output logic [SEL_W-1:0]    o_rf_wsel,
  output logic                o_alu_a_in,
  output logic                o_alu_b_in,
  output logic                o_alu_out,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_halted,
  output logic                o_illegal
);

  state_e     r_state;
  instr_cls_e w_cls;
  logic [3:0] w_op, w_x, w_y, w_z;
  logic       w_taken;

  assign w_op  = i_ir_data[15:12];
  assign w_x   = i_ir_data[11:8];
  assign w_y   = i_ir_data[7:4];
  assign w_z   = i_ir_data[3:0];
  assign w_cls = decode_cls(i_ir_data);

  hmmm_cond_eval u_cond_eval (
    .i_op      (w_op),
    .i_rf_zero (i_rf_zero),
    .i_rf_neg  (i_rf_neg),
    .o_taken   (w_taken)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      case (r_state)
        StIdle: r_state <= StF0;
        StF0:   r_state <= StF1;
        StF1:   if (i_mem_ready) r_state <= StD;
        StD: begin
          case (w_cls)
            ClsHalt: r_state <= StHlt;
            ClsNop:  r_state <= StF0;
            ClsIllegal: begin
`ifdef HMMM_ILLEGAL_TRAP_EN
              r_state <= StHlt;
`else
              r_state <= StF0;
`endif
            end
            default: r_state <= StE0;
          endcase
        end
        StE0: begin
          case (w_cls)
            ClsSetn, ClsLoadn, ClsStoren, ClsAddn, ClsAlu, ClsCalln: r_state <= StE1;
            ClsBranch: r_state <= w_taken ? StE1 : StF0;
            default:   r_state <= StF0;
          endcase
        end
        StE1: begin
          case (w_cls)
            ClsLoadn, ClsStoren: if (i_mem_ready) r_state <= StF0;
            ClsAddn, ClsAlu:     r_state <= StE2;
            default:             r_state <= StF0;
          endcase
        end
        StE2:    r_state <= StF0;
        StHlt:   r_state <= StHlt;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Every strobe is a pure function of the state register and the held IR,
  // so a single case arm per state keeps one bus driver per cycle.
  always_comb begin
    o_ir_in    = 1'b0;
    o_ir_out   = 1'b0;
    o_pc_out   = 1'b0;
    o_pc_in    = 1'b0;
    o_pc_inc   = 1'b0;
    o_mar_in   = 1'b0;
    o_mem_out  = 1'b0;
    o_mem_wr   = 1'b0;
    o_rf_out   = 1'b0;
    o_rf_in    = 1'b0;
    o_rf_rsel  = '0;
    o_rf_wsel  = '0;
    o_alu_a_in = 1'b0;
    o_alu_b_in = 1'b0;
    o_alu_out  = 1'b0;
    o_alu_op   = '0;
    o_halted   = 1'b0;
    o_illegal  = 1'b0;
    unique case (r_state)
      StIdle: ;
      StF0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
      end
      StF1: begin
        o_mem_out = 1'b1;
        o_ir_in   = 1'b1;
        o_pc_inc  = 1'b1;
      end
      StD: o_illegal = (w_cls == ClsIllegal);
      StE0: begin
        case (w_cls)
          ClsJumpr: begin
            o_rf_out  = 1'b1;
            o_rf_rsel = SEL_W'(w_x);
            o_pc_in   = 1'b1;
          end
          ClsSetn: begin
            o_ir_out   = 1'b1;
            o_alu_a_in = 1'b1;
          end
          ClsLoadn, ClsStoren: begin
            o_ir_out = 1'b1;
            o_mar_in = 1'b1;
          end
          ClsAddn: begin
            o_rf_out   = 1'b1;
            o_rf_rsel  = SEL_W'(w_x);
            o_alu_a_in = 1'b1;
          end
          ClsCopy: begin
            o_rf_out  = 1'b1;
            o_rf_rsel = SEL_W'(w_y);
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          ClsAlu: begin
            o_rf_out   = 1'b1;
            o_rf_rsel  = SEL_W'(w_y);
            o_alu_a_in = 1'b1;
          end
          ClsJumpn: begin
            o_ir_out = 1'b1;
            o_pc_in  = 1'b1;
          end
          ClsCalln: begin
            o_pc_out  = 1'b1;
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          ClsBranch: begin
            o_rf_out  = 1'b1;
            o_rf_rsel = SEL_W'(w_x);
          end
          default: ;
        endcase
      end
      StE1: begin
        case (w_cls)
          ClsSetn: begin
            o_alu_op  = ALU_OP_W'(ALU_SEXT);
            o_alu_out = 1'b1;
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          ClsLoadn: begin
            o_mem_out = 1'b1;
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          ClsStoren: begin
            o_rf_out  = 1'b1;
            o_rf_rsel = SEL_W'(w_x);
            o_mem_wr  = 1'b1;
          end
          ClsAddn: begin
            o_ir_out   = 1'b1;
            o_alu_b_in = 1'b1;
          end
          ClsAlu: begin
            o_rf_out   = 1'b1;
            o_rf_rsel  = SEL_W'(w_z);
            o_alu_b_in = 1'b1;
          end
          ClsCalln, ClsBranch: begin
            o_ir_out = 1'b1;
            o_pc_in  = 1'b1;
          end
          default: ;
        endcase
      end
      StE2: begin
        case (w_cls)
          ClsAddn: begin
            o_alu_op  = ALU_OP_W'(ALU_ADDI);
            o_alu_out = 1'b1;
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          ClsAlu: begin
            o_alu_op  = ALU_OP_W'(alu_op_of(w_op));
            o_alu_out = 1'b1;
            o_rf_in   = 1'b1;
            o_rf_wsel = SEL_W'(w_x);
          end
          default: ;
        endcase
      end
      StHlt: o_halted = 1'b1;
    endcase
  end

endmodule
